// File: rtl/pr_decouple_pkg.sv
// pr_decouple_pkg: state encoding and default timing constants for the PR decouple sequencer
package pr_decouple_pkg;
  typedef enum logic [1:0] {
    COUPLED   = 2'd0,
    DRAIN     = 2'd1,
    DECOUPLED = 2'd2,
    RECOUPLE  = 2'd3
  } pr_state_t;
  localparam int DEF_TIMEOUT_CYCLES  = 65535;
  localparam int DEF_RECOUPLE_CYCLES = 16;
endpackage

// File: rtl/pr_decouple_ctrl_axis_pkt_tracker.sv
// axis_pkt_tracker: flags an AXI4-Stream interface as mid-packet between a non-last and a last beat
module axis_pkt_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  input  logic last,
  input  logic clear,
  output logic busy
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= 1'b0;
    else busy <= clear ? 1'b0 : (valid && ready) ? !last : busy;
endmodule

// File: rtl/pr_decouple_ctrl.sv
// pr_decouple_ctrl: drains PCIe streams and cfg_mgmt, then isolates and resets the reconfigurable partition
module pr_decouple_ctrl
  import pr_decouple_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int RECOUPLE_CYCLES = DEF_RECOUPLE_CYCLES
) (
  input  logic       user_clk,
  input  logic       user_resetn,
  input  logic       decouple_req,
  input  logic       cq_tvalid,
  input  logic       cq_tready,
  input  logic       cq_tlast,
  input  logic       rc_tvalid,
  input  logic       rc_tready,
  input  logic       rc_tlast,
  input  logic       cc_tvalid,
  input  logic       cc_tready,
  input  logic       cc_tlast,
  input  logic       rq_tvalid,
  input  logic       rq_tlast,
  input  logic [3:0] rq_tready,
  input  logic       mgmt_read_en,
  input  logic       mgmt_write_en,
  input  logic       mgmt_read_write_done,
  output logic       pr_decouple,
  output logic       rp_resetn,
  output logic [1:0] decouple_state,
  output logic       drain_timeout
);
  localparam int MAXC = (TIMEOUT_CYCLES > RECOUPLE_CYCLES) ? TIMEOUT_CYCLES : RECOUPLE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  pr_state_t     state, nxt;
  logic [TW-1:0] timer;
  logic [3:0]    valid, ready, last, busy;
  logic          mgmt_busy, mgmt_en, quiet, enter_dec, timeout_hit, recouple_hit;
  logic          unused_rq_ready;
  assign unused_rq_ready = ^rq_tready[3:1];
  assign valid   = {cq_tvalid, rc_tvalid, cc_tvalid, rq_tvalid};
  assign ready   = {cq_tready, rc_tready, cc_tready, rq_tready[0]};
  assign last    = {cq_tlast, rc_tlast, cc_tlast, rq_tlast};
  assign mgmt_en = mgmt_read_en | mgmt_write_en;
  assign quiet   = ~|busy & ~mgmt_busy & ~|(valid & ready) & ~mgmt_en;
  assign timeout_hit  = timer == TW'(TIMEOUT_CYCLES - 1);
  assign recouple_hit = timer == TW'(RECOUPLE_CYCLES - 1);
  // the decoupler truncates open packets, so tracking restarts clean on isolation
  assign enter_dec = (nxt == DECOUPLED) && (state != DECOUPLED);
  assign decouple_state = state;
  for (genvar i = 0; i < 4; i++) begin : g_trk
    axis_pkt_tracker u_trk (
      .clk  (user_clk),
      .rst_n(user_resetn),
      .valid(valid[i]),
      .ready(ready[i]),
      .last (last[i]),
      .clear(enter_dec),
      .busy (busy[i])
    );
  end
  always_comb begin
    nxt = state;
    case (state)
      COUPLED:   nxt = decouple_req ? DRAIN : COUPLED;
      DRAIN:     nxt = !decouple_req ? COUPLED : (quiet || timeout_hit) ? DECOUPLED : DRAIN;
      DECOUPLED: nxt = decouple_req ? DECOUPLED : RECOUPLE;
      default:   nxt = decouple_req ? DECOUPLED : recouple_hit ? COUPLED : RECOUPLE;
    endcase
  end
  always_ff @(posedge user_clk or negedge user_resetn)
    if (!user_resetn) begin
      state         <= COUPLED;
      timer         <= '0;
      pr_decouple   <= 1'b0;
      rp_resetn     <= 1'b0;
      drain_timeout <= 1'b0;
      mgmt_busy     <= 1'b0;
    end else begin
      state         <= nxt;
      timer         <= (nxt != state) ? '0 : (&timer) ? timer : timer + TW'(1);
      pr_decouple   <= (nxt == DECOUPLED) || (nxt == RECOUPLE);
      rp_resetn     <= nxt != DECOUPLED;
      drain_timeout <= (state == COUPLED && nxt == DRAIN) ? 1'b0
                     : (state == DRAIN && nxt == DECOUPLED && !quiet) ? 1'b1 : drain_timeout;
      mgmt_busy     <= enter_dec ? 1'b0 : mgmt_en ? 1'b1 : mgmt_read_write_done ? 1'b0 : mgmt_busy;
    end
endmodule
